// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: unit codes, queue-entry
// field widths and the round-robin grant encoding.
package writeback_arbiter_pkg;

  localparam int UNIT_CODE_W = 3;

  localparam logic [UNIT_CODE_W-1:0] FX_UNIT_CODE   = 3'd0;
  localparam logic [UNIT_CODE_W-1:0] LDST_UNIT_CODE = 3'd2;

  // Default queue-entry field widths: {en1, en2, addr1, addr2, val1, val2}
  localparam int WB_EN_W   = 1;
  localparam int WB_ADDR_W = 5;
  localparam int WB_VAL_W  = 64;

  // Total packed width of one queue entry for given field widths.
  function automatic int entry_width(input int addr_w, input int val_w);
    return 2 * WB_EN_W + 2 * addr_w + 2 * val_w;
  endfunction

  // Which requester was granted most recently.
  typedef enum logic {
    GRANT_FX = 1'b0,
    GRANT_LS = 1'b1
  } grant_e;

endpackage

// File: rtl/wb_req_fifo.sv
// Per-requester writeback queue: in-order circular buffer with a registered
// occupancy count. A push while full and a pop while empty are ignored.
module wb_req_fifo #(
  parameter int DATA_W = 140,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic [CNT_W-1:0]  o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign w_push  = i_push && (r_count < CNT_W'(DEPTH));
  assign w_pop   = i_pop && (r_count != '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage write; contents need no reset because the count gates visibility.
  always_ff @(posedge clock_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy tracking; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges the FX and load/store writeback streams onto one register-file
// write port. Each requester feeds its own queue; a round-robin arbiter
// pops one head per stall-free cycle into the registered writeback outputs.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int                     regWidth     = WB_ADDR_W,
  parameter int                     addressSize  = WB_VAL_W,
  parameter int                     fifoDepth    = 2,
  parameter logic [UNIT_CODE_W-1:0] FXUnitCode   = FX_UNIT_CODE,
  parameter logic [UNIT_CODE_W-1:0] LdStUnitCode = LDST_UNIT_CODE
) (
  input  logic                   clock_i,
  input  logic                   reset_i,

  input  logic                   fxValid_i,
  output logic                   fxReady_o,
  input  logic                   fxReg1En_i,
  input  logic                   fxReg2En_i,
  input  logic [regWidth-1:0]    fxReg1Addr_i,
  input  logic [regWidth-1:0]    fxReg2Addr_i,
  input  logic [addressSize-1:0] fxReg1Val_i,
  input  logic [addressSize-1:0] fxReg2Val_i,

  input  logic                   lsValid_i,
  output logic                   lsReady_o,
  input  logic                   lsReg1En_i,
  input  logic                   lsReg2En_i,
  input  logic [regWidth-1:0]    lsReg1Addr_i,
  input  logic [regWidth-1:0]    lsReg2Addr_i,
  input  logic [addressSize-1:0] lsReg1Val_i,
  input  logic [addressSize-1:0] lsReg2Val_i,

  input  logic                   wbStall_i,

  output logic                   wbValid_o,
  output logic [UNIT_CODE_W-1:0] functionalUnitCode_o,
  output logic                   reg1WritebackEnable_o,
  output logic                   reg2WritebackEnable_o,
  output logic [regWidth-1:0]    reg1WritebackAddress_o,
  output logic [regWidth-1:0]    reg2WritebackAddress_o,
  output logic [addressSize-1:0] reg1WritebackVal_o,
  output logic [addressSize-1:0] reg2WritebackVal_o
);

  localparam int ENTRY_W = entry_width(regWidth, addressSize);
  localparam int CNT_W   = $clog2(fifoDepth + 1);

  // Entry layout, MSB first: en1 | en2 | addr1 | addr2 | val1 | val2
  localparam int EN1_B   = ENTRY_W - 1;
  localparam int EN2_B   = ENTRY_W - 2;
  localparam int ADDR1_H = ENTRY_W - 3;
  localparam int ADDR2_H = ADDR1_H - regWidth;
  localparam int VAL1_H  = 2 * addressSize - 1;
  localparam int VAL2_H  = addressSize - 1;

  logic [ENTRY_W-1:0] w_fx_entry;
  logic [ENTRY_W-1:0] w_ls_entry;
  logic [ENTRY_W-1:0] w_fx_head;
  logic [ENTRY_W-1:0] w_ls_head;
  logic [ENTRY_W-1:0] w_win_head;
  logic [CNT_W-1:0]   w_fx_count;
  logic [CNT_W-1:0]   w_ls_count;
  logic               w_fx_push;
  logic               w_ls_push;
  logic               w_fx_nonempty;
  logic               w_ls_nonempty;
  logic               w_grant_fx;
  logic               w_grant_ls;

  grant_e                 r_last_grant;
  logic                   r_wb_valid;
  logic [UNIT_CODE_W-1:0] r_unit_code;
  logic                   r_en1;
  logic                   r_en2;
  logic [regWidth-1:0]    r_addr1;
  logic [regWidth-1:0]    r_addr2;
  logic [addressSize-1:0] r_val1;
  logic [addressSize-1:0] r_val2;

  // Ready depends only on registered occupancy, so no stall/valid path reaches it.
  assign fxReady_o = (w_fx_count < CNT_W'(fifoDepth));
  assign lsReady_o = (w_ls_count < CNT_W'(fifoDepth));

  // Transfers with no enable set are acknowledged but never stored.
  assign w_fx_push = fxValid_i && fxReady_o && (fxReg1En_i || fxReg2En_i);
  assign w_ls_push = lsValid_i && lsReady_o && (lsReg1En_i || lsReg2En_i);

  assign w_fx_entry = {fxReg1En_i, fxReg2En_i, fxReg1Addr_i, fxReg2Addr_i,
                       fxReg1Val_i, fxReg2Val_i};
  assign w_ls_entry = {lsReg1En_i, lsReg2En_i, lsReg1Addr_i, lsReg2Addr_i,
                       lsReg1Val_i, lsReg2Val_i};

  assign w_fx_nonempty = (w_fx_count != '0);
  assign w_ls_nonempty = (w_ls_count != '0);

  wb_req_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (fifoDepth),
    .CNT_W  (CNT_W)
  ) u_fx_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .i_push  (w_fx_push),
    .i_data  (w_fx_entry),
    .i_pop   (w_grant_fx),
    .o_head  (w_fx_head),
    .o_count (w_fx_count)
  );

  wb_req_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (fifoDepth),
    .CNT_W  (CNT_W)
  ) u_ls_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .i_push  (w_ls_push),
    .i_data  (w_ls_entry),
    .i_pop   (w_grant_ls),
    .o_head  (w_ls_head),
    .o_count (w_ls_count)
  );

  // Round-robin choice between non-empty queues; nothing is granted while stalled.
  always_comb begin
    w_grant_fx = 1'b0;
    w_grant_ls = 1'b0;
    if (!wbStall_i) begin
      if (w_fx_nonempty && w_ls_nonempty) begin
        if (r_last_grant == GRANT_LS) begin
          w_grant_fx = 1'b1;
        end else begin
          w_grant_ls = 1'b1;
        end
      end else if (w_fx_nonempty) begin
        w_grant_fx = 1'b1;
      end else if (w_ls_nonempty) begin
        w_grant_ls = 1'b1;
      end
    end
  end

  assign w_win_head = w_grant_fx ? w_fx_head : w_ls_head;

  // Writeback output registers and grant history; a stall freezes everything.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      r_last_grant <= GRANT_LS;
      r_wb_valid   <= 1'b0;
      r_unit_code  <= '0;
      r_en1        <= 1'b0;
      r_en2        <= 1'b0;
      r_addr1      <= '0;
      r_addr2      <= '0;
      r_val1       <= '0;
      r_val2       <= '0;
    end else if (!wbStall_i) begin
      if (w_grant_fx || w_grant_ls) begin
        r_wb_valid   <= 1'b1;
        r_unit_code  <= w_grant_fx ? FXUnitCode : LdStUnitCode;
        r_last_grant <= w_grant_fx ? GRANT_FX : GRANT_LS;
        r_en1        <= w_win_head[EN1_B];
        r_en2        <= w_win_head[EN2_B];
        r_addr1      <= w_win_head[ADDR1_H -: regWidth];
        r_addr2      <= w_win_head[ADDR2_H -: regWidth];
        r_val1       <= w_win_head[VAL1_H -: addressSize];
        r_val2       <= w_win_head[VAL2_H -: addressSize];
      end else begin
        r_wb_valid <= 1'b0;
        r_en1      <= 1'b0;
        r_en2      <= 1'b0;
      end
    end
  end

  assign wbValid_o              = r_wb_valid;
  assign functionalUnitCode_o   = r_unit_code;
  assign reg1WritebackEnable_o  = r_en1;
  assign reg2WritebackEnable_o  = r_en2;
  assign reg1WritebackAddress_o = r_addr1;
  assign reg2WritebackAddress_o = r_addr2;
  assign reg1WritebackVal_o     = r_val1;
  assign reg2WritebackVal_o     = r_val2;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus a randomized run,
// all checked every cycle against a queue-based reference model.
module tb_writeback_arbiter;

  localparam int RW    = 5;
  localparam int AW    = 64;
  localparam int DEPTH = 2;

  typedef struct {
    logic          en1;
    logic          en2;
    logic [RW-1:0] a1;
    logic [RW-1:0] a2;
    logic [AW-1:0] v1;
    logic [AW-1:0] v2;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fx_valid, fx_ready, fx_en1, fx_en2;
  logic [RW-1:0] fx_a1, fx_a2;
  logic [AW-1:0] fx_v1, fx_v2;
  logic          ls_valid, ls_ready, ls_en1, ls_en2;
  logic [RW-1:0] ls_a1, ls_a2;
  logic [AW-1:0] ls_v1, ls_v2;
  logic          stall;
  logic          wb_valid, wb_en1, wb_en2;
  logic [2:0]    wb_code;
  logic [RW-1:0] wb_a1, wb_a2;
  logic [AW-1:0] wb_v1, wb_v2;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  entry_t        fx_q[$];
  entry_t        ls_q[$];
  bit            model_known = 1'b0;
  bit            last_was_ls;
  logic          e_valid, e_en1, e_en2;
  logic [2:0]    e_code;
  logic [RW-1:0] e_a1, e_a2;
  logic [AW-1:0] e_v1, e_v2;

  writeback_arbiter #(
    .regWidth     (RW),
    .addressSize  (AW),
    .fifoDepth    (DEPTH),
    .FXUnitCode   (3'd0),
    .LdStUnitCode (3'd2)
  ) dut (
    .clock_i                (clk),
    .reset_i                (rst_n),
    .fxValid_i              (fx_valid),
    .fxReady_o              (fx_ready),
    .fxReg1En_i             (fx_en1),
    .fxReg2En_i             (fx_en2),
    .fxReg1Addr_i           (fx_a1),
    .fxReg2Addr_i           (fx_a2),
    .fxReg1Val_i            (fx_v1),
    .fxReg2Val_i            (fx_v2),
    .lsValid_i              (ls_valid),
    .lsReady_o              (ls_ready),
    .lsReg1En_i             (ls_en1),
    .lsReg2En_i             (ls_en2),
    .lsReg1Addr_i           (ls_a1),
    .lsReg2Addr_i           (ls_a2),
    .lsReg1Val_i            (ls_v1),
    .lsReg2Val_i            (ls_v2),
    .wbStall_i              (stall),
    .wbValid_o              (wb_valid),
    .functionalUnitCode_o   (wb_code),
    .reg1WritebackEnable_o  (wb_en1),
    .reg2WritebackEnable_o  (wb_en2),
    .reg1WritebackAddress_o (wb_a1),
    .reg2WritebackAddress_o (wb_a2),
    .reg1WritebackVal_o     (wb_v1),
    .reg2WritebackVal_o     (wb_v2)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    rst_n = 1'b1; stall = 1'b0;
    fx_valid = 1'b0; fx_en1 = 1'b0; fx_en2 = 1'b0; fx_a1 = '0; fx_a2 = '0; fx_v1 = '0; fx_v2 = '0;
    ls_valid = 1'b0; ls_en1 = 1'b0; ls_en2 = 1'b0; ls_a1 = '0; ls_a2 = '0; ls_v1 = '0; ls_v2 = '0;
  endtask

  // One clock: checks ready against the model, advances the model by the
  // rules of one edge, then compares all outputs at the following negedge.
  task automatic step();
    entry_t e;
    bit fx_acc, ls_acc;
    int win;
    if (model_known) begin
      n_cmp++;
      if (fx_ready !== (fx_q.size() < DEPTH)) begin
        n_fail++; $display("FAIL fx_ready: got %b want %b", fx_ready, fx_q.size() < DEPTH);
      end
      n_cmp++;
      if (ls_ready !== (ls_q.size() < DEPTH)) begin
        n_fail++; $display("FAIL ls_ready: got %b want %b", ls_ready, ls_q.size() < DEPTH);
      end
    end
    if (!rst_n) begin
      fx_q.delete(); ls_q.delete();
      e_valid = 0; e_en1 = 0; e_en2 = 0; e_code = 0; e_a1 = 0; e_a2 = 0; e_v1 = 0; e_v2 = 0;
      last_was_ls = 1'b1;
      model_known = 1'b1;
    end else if (model_known) begin
      fx_acc = fx_valid && (fx_q.size() < DEPTH);
      ls_acc = ls_valid && (ls_q.size() < DEPTH);
      if (!stall) begin
        win = -1;
        if (fx_q.size() > 0 && ls_q.size() > 0) win = last_was_ls ? 0 : 1;
        else if (fx_q.size() > 0) win = 0;
        else if (ls_q.size() > 0) win = 1;
        if (win >= 0) begin
          e = (win == 0) ? fx_q.pop_front() : ls_q.pop_front();
          e_valid = 1; e_code = (win == 0) ? 3'd0 : 3'd2;
          e_en1 = e.en1; e_en2 = e.en2; e_a1 = e.a1; e_a2 = e.a2; e_v1 = e.v1; e_v2 = e.v2;
          last_was_ls = (win == 1);
        end else begin
          e_valid = 0; e_en1 = 0; e_en2 = 0;
        end
      end
      if (fx_acc && (fx_en1 || fx_en2))
        fx_q.push_back('{en1: fx_en1, en2: fx_en2, a1: fx_a1, a2: fx_a2, v1: fx_v1, v2: fx_v2});
      if (ls_acc && (ls_en1 || ls_en2))
        ls_q.push_back('{en1: ls_en1, en2: ls_en2, a1: ls_a1, a2: ls_a2, v1: ls_v1, v2: ls_v2});
    end
    @(posedge clk);
    @(negedge clk);
    if (model_known) begin
      n_cmp++;
      if (wb_valid !== e_valid) begin
        n_fail++; $display("FAIL wb_valid: got %b want %b", wb_valid, e_valid);
      end
      n_cmp++;
      if (wb_code !== e_code) begin
        n_fail++; $display("FAIL unit_code: got %0d want %0d", wb_code, e_code);
      end
      n_cmp++;
      if ({wb_en1, wb_en2} !== {e_en1, e_en2}) begin
        n_fail++; $display("FAIL enables: got %b%b want %b%b", wb_en1, wb_en2, e_en1, e_en2);
      end
      n_cmp++;
      if ({wb_a1, wb_a2} !== {e_a1, e_a2}) begin
        n_fail++; $display("FAIL addrs: got %0d/%0d want %0d/%0d", wb_a1, wb_a2, e_a1, e_a2);
      end
      n_cmp++;
      if ({wb_v1, wb_v2} !== {e_v1, e_v2}) begin
        n_fail++; $display("FAIL vals: got %h/%h want %h/%h", wb_v1, wb_v2, e_v1, e_v2);
      end
      n_cmp++;
      if (wb_valid === 1'b1 && !(wb_en1 || wb_en2)) begin
        n_fail++; $display("FAIL valid_no_enable: got en %b%b want at least one set", wb_en1, wb_en2);
      end
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    fx_valid = 1'b1; fx_en1 = 1'b1; fx_a1 = 5'd3;
    ls_valid = 1'b1; ls_en1 = 1'b1; ls_a1 = 5'd4;
    step();
    step();
    idle_inputs();
    n_cmp++;
    if (wb_valid !== 1'b0 || fx_ready !== 1'b1 || ls_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_state: got v=%b fr=%b lr=%b want 0 1 1", wb_valid, fx_ready, ls_ready);
    end
    for (int i = 0; i < 3; i++) step();
    n_cmp++;
    if (wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_output: got %b want 0", wb_valid);
    end
  endtask

  task automatic test_single_fx();
    do_reset();
    fx_valid = 1'b1; fx_en1 = 1'b1; fx_a1 = 5'd5; fx_v1 = 64'hDEAD;
    step();
    idle_inputs();
    n_cmp++;
    if (wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_early: got %b want 0", wb_valid);
    end
    step();
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_code !== 3'd0 || wb_a1 !== 5'd5 || wb_v1 !== 64'hDEAD || wb_en1 !== 1'b1) begin
      n_fail++; $display("FAIL single_out: got v=%b c=%0d a=%0d val=%h want 1 0 5 dead", wb_valid, wb_code, wb_a1, wb_v1);
    end
    step();
    n_cmp++;
    if (wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_after: got %b want 0", wb_valid);
    end
  endtask

  task automatic test_contention();
    int fx_sent = 0, ls_sent = 0;
    logic [2:0]    codes[$];
    logic [RW-1:0] addrs[$];
    logic [2:0]    want_code[6] = '{3'd0, 3'd2, 3'd0, 3'd2, 3'd0, 3'd2};
    logic [RW-1:0] want_addr[6] = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13};
    bit fx_took, ls_took;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      fx_valid = (fx_sent < 3); fx_en1 = 1'b1; fx_a1 = RW'(fx_sent + 1);
      ls_valid = (ls_sent < 3); ls_en1 = 1'b1; ls_a1 = RW'(ls_sent + 11);
      fx_took = fx_valid && fx_ready;
      ls_took = ls_valid && ls_ready;
      step();
      if (fx_took) fx_sent++;
      if (ls_took) ls_sent++;
      if (wb_valid === 1'b1) begin
        codes.push_back(wb_code);
        addrs.push_back(wb_a1);
      end
    end
    idle_inputs();
    n_cmp++;
    if (codes.size() != 6) begin
      n_fail++; $display("FAIL contention_count: got %0d want 6", codes.size());
    end
    for (int i = 0; i < 6 && i < codes.size(); i++) begin
      n_cmp++;
      if (codes[i] !== want_code[i] || addrs[i] !== want_addr[i]) begin
        n_fail++; $display("FAIL contention_order[%0d]: got code %0d addr %0d want code %0d addr %0d",
                           i, codes[i], addrs[i], want_code[i], want_addr[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] addrs[$];
    do_reset();
    stall = 1'b1;
    for (int c = 0; c < 6; c++) begin
      ls_valid = 1'b1; ls_en1 = 1'b1; ls_a1 = RW'(c + 1); ls_v1 = AW'(c + 100);
      step();
      n_cmp++;
      if (wb_valid !== 1'b0) begin
        n_fail++; $display("FAIL stall_frozen: got %b want 0", wb_valid);
      end
    end
    n_cmp++;
    if (ls_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_full: got ls_ready %b want 0", ls_ready);
    end
    idle_inputs();
    for (int c = 0; c < 5; c++) begin
      step();
      if (wb_valid === 1'b1) addrs.push_back(wb_a1);
    end
    n_cmp++;
    if (addrs.size() != 2 || addrs[0] !== 5'd1 || addrs[1] !== 5'd2) begin
      n_fail++; $display("FAIL stall_release: got %0d entries want 2 entries addr 1,2", addrs.size());
    end
  endtask

  task automatic test_null_entry();
    do_reset();
    ls_valid = 1'b1;
    step();
    ls_en1 = 1'b1; ls_a1 = 5'd7; ls_v1 = 64'h77;
    step();
    idle_inputs();
    n_cmp++;
    if (wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL null_not_output: got %b want 0", wb_valid);
    end
    step();
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_a1 !== 5'd7 || wb_code !== 3'd2) begin
      n_fail++; $display("FAIL null_then_7: got v=%b a=%0d c=%0d want 1 7 2", wb_valid, wb_a1, wb_code);
    end
    step();
    n_cmp++;
    if (wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL null_after: got %b want 0", wb_valid);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    stall = 1'b1;
    fx_valid = 1'b1; fx_en1 = 1'b1; fx_a1 = 5'd9;
    ls_valid = 1'b1; ls_en2 = 1'b1; ls_a2 = 5'd19;
    step();
    step();
    n_cmp++;
    if (fx_ready !== 1'b0 || ls_ready !== 1'b0) begin
      n_fail++; $display("FAIL midflight_full: got fr=%b lr=%b want 0 0", fx_ready, ls_ready);
    end
    stall = 1'b0;
    rst_n = 1'b0;
    step();
    idle_inputs();
    for (int c = 0; c < 5; c++) begin
      step();
      n_cmp++;
      if (wb_valid !== 1'b0) begin
        n_fail++; $display("FAIL midflight_stale: got %b want 0", wb_valid);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      rst_n    = ($urandom_range(0, 299) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      fx_valid = $urandom_range(0, 1);
      fx_en1   = ($urandom_range(0, 3) != 0);
      fx_en2   = $urandom_range(0, 1);
      fx_a1    = RW'($urandom); fx_a2 = RW'($urandom);
      fx_v1    = {$urandom, $urandom}; fx_v2 = {$urandom, $urandom};
      ls_valid = $urandom_range(0, 1);
      ls_en1   = $urandom_range(0, 1);
      ls_en2   = ($urandom_range(0, 2) == 0);
      ls_a1    = RW'($urandom); ls_a2 = RW'($urandom);
      ls_v1    = {$urandom, $urandom}; ls_v2 = {$urandom, $urandom};
      step();
    end
    idle_inputs();
    for (int c = 0; c < 6; c++) step();
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single_fx();
    test_contention();
    test_backpressure();
    test_null_entry();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Params: regWidth, default 5, register address width; addressSize, default 64, value width; fifoDepth, default 2, entries per requester queue; FXUnitCode, default 0; LdStUnitCode, default 2.
REQ-002 Port: clock_i  in  1  sole clock, all state on rising edge.
REQ-003 Port: reset_i  in  1  reset, synchronous, active-low.
REQ-004 Ports, FX requester: fxValid_i in 1; fxReady_o out 1; fxReg1En_i, fxReg2En_i in 1 each; fxReg1Addr_i, fxReg2Addr_i in regWidth each; fxReg1Val_i, fxReg2Val_i in addressSize each.
REQ-005 Ports, LS requester: lsValid_i, lsReady_o, lsReg1En_i, lsReg2En_i, lsReg1Addr_i, lsReg2Addr_i, lsReg1Val_i, lsReg2Val_i; same directions and widths as REQ-004.
REQ-006 Port: wbStall_i  in  1  register file cannot accept a writeback this cycle.
REQ-007 Ports, writeback out: wbValid_o 1; functionalUnitCode_o 3; reg1WritebackEnable_o, reg2WritebackEnable_o 1 each; reg1WritebackAddress_o, reg2WritebackAddress_o regWidth each; reg1WritebackVal_o, reg2WritebackVal_o addressSize each; all registered.

Function
REQ-008 Transfer occurs on a requester when valid_i and ready_o are both 1 at a rising edge.
REQ-009 ready_o = (queue count < fifoDepth), from registered count only; no combinational path from wbStall_i or valid_i.
REQ-010 Transfer with both En inputs 0: accepted, not queued, never appears at the output.
REQ-011 Each requester has an independent FIFO of fifoDepth entries {en1,en2,addr1,addr2,val1,val2}, in-order, circular pointers wrapping at fifoDepth.
REQ-012 Same-edge push and pop on one queue: both occur, count unchanged, no data lost.
REQ-013 Earliest output: entry pushed at edge N drives wbValid_o=1 after edge N+1 (one-cycle latency through an empty queue).
REQ-014 Arbitration at each edge with wbStall_i=0: exactly one non-empty queue -> that queue wins; both non-empty -> queue not granted last (round-robin lastGrant register) wins; none -> no winner.
REQ-015 Winner: head popped, output registers load head fields, wbValid_o<=1, functionalUnitCode_o<=FXUnitCode or LdStUnitCode, lastGrant<=winner.
REQ-016 No winner and wbStall_i=0: wbValid_o, reg1WritebackEnable_o, reg2WritebackEnable_o <=0; address/value/unit-code outputs hold.
REQ-017 wbStall_i=1: no pop, all outputs hold, lastGrant holds; queues still accept pushes until full.
REQ-018 Enables on the output equal the queued enables; wbValid_o=1 implies at least one enable is 1.
REQ-019 Each granted entry is presented exactly once; an entry output under wbStall_i=1 counts as delivered on the first stall-free edge.

Reset
REQ-020 reset_i=0 at an edge: both queues empty, pointers 0, fxReady_o=lsReady_o=1 next cycle, wbValid_o=0, both enable outputs 0, functionalUnitCode_o=0, addresses/values 0, lastGrant=LS (FX wins first tie).
REQ-021 reset_i=0 mid-operation discards all queued and in-flight entries; transfers presented that edge are not accepted.

Structure
REQ-022 Shared package holds the unit codes (FXUnitCode, LdStUnitCode) and the queue-entry field widths.
REQ-023 One sub-module, wb_req_fifo, instantiated once per requester, providing push/pop/count/head; arbitration and output registers live in writeback_arbiter.

Verification
REQ-024 Reset: hold reset_i=0 two cycles with both valid_i=1 -> no output, wbValid_o=0, both ready_o=1 after release.
REQ-025 Single FX write: push en1=1,addr1=5,val1=0xDEAD at edge N -> after N+1 wbValid_o=1, unit code 0, addr 5, val 0xDEAD; after N+2 wbValid_o=0.
REQ-026 Contention: FX and LS each push 3 entries back-to-back from reset -> output order FX,LS,FX,LS,FX,LS, unit codes 0,2 alternating.
REQ-027 Backpressure: wbStall_i=1 for 6 cycles while LS pushes continuously -> lsReady_o low after 2 queued (depth 2), outputs frozen; on release all entries delivered in order, none duplicated.
REQ-028 Null entry: LS push with both En=0 then push addr1=7 -> only addr 7 appears, one cycle after its push.
REQ-029 Reset mid-flight: both queues full, reset_i=0 one cycle -> queues empty, wbValid_o=0, no stale entry emitted afterwards.
